// File: rtl/flash_load_pkg.sv
// Shared types and helpers for the flash load sequencer: FSM state encoding,
// region index width and extraction of one entry from the packed job tables.
package flash_load_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_START,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_NEXT,
        ST_DONE,
        ST_ERROR
    } state_e;

    localparam int MAX_REGIONS = 8;

    function automatic int region_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Tables are zero-padded to MAX_REGIONS entries before slicing.
    function automatic logic [15:0] entry16(input logic [MAX_REGIONS*16-1:0] tbl, input int i);
        return tbl[i*16 +: 16];
    endfunction

    function automatic logic [23:0] entry24(input logic [MAX_REGIONS*24-1:0] tbl, input int i);
        return tbl[i*24 +: 24];
    endfunction

endpackage

// File: rtl/flash_load_if.sv
// Flash reader handshake plus cartridge write port, seen from the sequencer
// (master) and from the reader / memory side (slave).
interface flash_load_if #(
    parameter int A_BITS   = 14,
    parameter int REGION_W = 1
);
    logic                fl_start;
    logic [15:0]         fl_start_addr;
    logic [23:0]         fl_offset;
    logic [15:0]         fl_amount;
    logic                fl_busy;
    logic                fl_req;
    logic                fl_ack;
    logic [A_BITS-1:0]   fl_a;
    logic [7:0]          fl_q;
    logic                wr_en;
    logic [A_BITS-1:0]   wr_addr;
    logic [7:0]          wr_data;
    logic [REGION_W-1:0] wr_region;

    modport master (
        output fl_start, fl_start_addr, fl_offset, fl_amount, fl_ack,
        output wr_en, wr_addr, wr_data, wr_region,
        input  fl_busy, fl_req, fl_a, fl_q
    );

    modport slave (
        input  fl_start, fl_start_addr, fl_offset, fl_amount, fl_ack,
        input  wr_en, wr_addr, wr_data, wr_region,
        output fl_busy, fl_req, fl_a, fl_q
    );
endinterface

// File: rtl/flash_load_sequencer_toggle_strobe.sv
// Turns the flash reader's req toggle into a one-cycle write strobe with the
// address, data and region tag registered alongside it.
module toggle_strobe #(
    parameter int A_BITS = 14,
    parameter int TAG_W  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture_en_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic              req_i,
    input  logic [A_BITS-1:0] addr_i,
    input  logic [7:0]        data_i,
    output logic              ack_o,
    output logic              hit_o,
    output logic              strobe_o,
    output logic [A_BITS-1:0] addr_o,
    output logic [7:0]        data_o,
    output logic [TAG_W-1:0]  tag_o
);

    logic              req_q;
    logic              strobe_q;
    logic [A_BITS-1:0] addr_q;
    logic [7:0]        data_q;
    logic [TAG_W-1:0]  tag_q;

    assign hit_o = capture_en_i && (req_i != req_q);

    // req_q keeps sampling through reset so no phantom toggle follows it.
    always_ff @(posedge clk) begin
        req_q <= req_i;
        if (reset) begin
            strobe_q <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            tag_q    <= '0;
        end else begin
            strobe_q <= hit_o;
            if (hit_o) begin
                addr_q <= addr_i;
                data_q <= data_i;
                tag_q  <= tag_i;
            end
        end
    end

    assign ack_o    = req_q;
    assign strobe_o = strobe_q;
    assign addr_o   = addr_q;
    assign data_o   = data_q;
    assign tag_o    = tag_q;

endmodule

// File: rtl/flash_load_sequencer.sv
// Boot-time loader: walks the region table through one SPI flash reader,
// producing tagged write strobes, per-region checksums and a busy watchdog.
module flash_load_sequencer
    import flash_load_pkg::*;
#(
    parameter int                      REGIONS       = 2,
    parameter int                      A_BITS        = 14,
    parameter logic [REGIONS*16-1:0]   START_ADDRS   = {REGIONS{16'h8000}},
    parameter logic [REGIONS*24-1:0]   FLASH_OFFSETS = '0,
    parameter logic [REGIONS*16-1:0]   AMOUNTS       = {REGIONS{16'd8192}},
    parameter int unsigned             TIMEOUT       = 32'd1 << 20
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            slot_valid_i,
    input  logic [REGIONS-1:0]              region_en_i,
    input  logic                            reload_i,
    flash_load_if.master                    bus,
    output logic                            spi_sel_flash_o,
    output logic                            hold_reset_o,
    output logic                            done_o,
    output logic                            error_o,
    output logic [region_w(REGIONS)-1:0]    err_region_o,
    output logic [15:0]                     checksum_o,
    output logic                            checksum_valid_o
);

    localparam int REGION_W = region_w(REGIONS);
    localparam int WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_e              state_q, state_d;
    logic [REGION_W-1:0] idx_q, idx_d;
    logic [WD_W-1:0]     wdog_q, wdog_d;
    logic [15:0]         sum_q, sum_d;
    logic                loaded_q, loaded_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [REGION_W-1:0] err_region_q, err_region_d;
    logic [15:0]         checksum_q, checksum_d;
    logic                cks_valid_q, cks_valid_d;

    logic [MAX_REGIONS*16-1:0] start_tbl;
    logic [MAX_REGIONS*24-1:0] offset_tbl;
    logic [MAX_REGIONS*16-1:0] amount_tbl;
    logic [15:0]               amount_cur;
    logic                      capture_en;
    logic                      hit;
    logic                      last;

    always_comb begin
        start_tbl                    = '0;
        offset_tbl                   = '0;
        amount_tbl                   = '0;
        start_tbl[REGIONS*16-1:0]    = START_ADDRS;
        offset_tbl[REGIONS*24-1:0]   = FLASH_OFFSETS;
        amount_tbl[REGIONS*16-1:0]   = AMOUNTS;
    end

    assign amount_cur        = entry16(amount_tbl, int'(idx_q));
    assign bus.fl_start_addr = entry16(start_tbl, int'(idx_q));
    assign bus.fl_offset     = entry24(offset_tbl, int'(idx_q));
    assign bus.fl_amount     = amount_cur;
    assign bus.fl_start      = (state_q == ST_START);
    assign capture_en        = (state_q == ST_WAIT_HI) || (state_q == ST_WAIT_LO);
    assign last              = (idx_q == REGION_W'(REGIONS - 1));

    toggle_strobe #(.A_BITS(A_BITS), .TAG_W(REGION_W)) u_strobe (
        .clk          (clk),
        .reset        (reset),
        .capture_en_i (capture_en),
        .tag_i        (idx_q),
        .req_i        (bus.fl_req),
        .addr_i       (bus.fl_a),
        .data_i       (bus.fl_q),
        .ack_o        (bus.fl_ack),
        .hit_o        (hit),
        .strobe_o     (bus.wr_en),
        .addr_o       (bus.wr_addr),
        .data_o       (bus.wr_data),
        .tag_o        (bus.wr_region)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            wdog_q       <= '0;
            sum_q        <= '0;
            loaded_q     <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_region_q <= '0;
            checksum_q   <= '0;
            cks_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            wdog_q       <= wdog_d;
            sum_q        <= sum_d;
            loaded_q     <= loaded_d;
            done_q       <= done_d;
            error_q      <= error_d;
            err_region_q <= err_region_d;
            checksum_q   <= checksum_d;
            cks_valid_q  <= cks_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        wdog_d       = wdog_q;
        sum_d        = sum_q;
        loaded_d     = loaded_q;
        done_d       = done_q;
        error_d      = error_q;
        err_region_d = err_region_q;
        checksum_d   = checksum_q;
        cks_valid_d  = cks_valid_q;

        unique case (state_q)
            // Busy low guards against a reset that landed in the middle of a load.
            ST_IDLE: if (slot_valid_i && !bus.fl_busy) state_d = ST_ARM;
            ST_ARM: begin
                loaded_d = 1'b0;
                state_d  = (region_en_i[idx_q] && amount_cur != 16'd0) ? ST_START : ST_NEXT;
            end
            ST_START: begin
                sum_d    = '0;
                wdog_d   = WD_W'(TIMEOUT);
                loaded_d = 1'b1;
                state_d  = ST_WAIT_HI;
            end
            ST_WAIT_HI, ST_WAIT_LO: begin
                if (wdog_q <= WD_W'(1)) begin
                    state_d      = ST_ERROR;
                    error_d      = 1'b1;
                    err_region_d = idx_q;
                end else begin
                    wdog_d = wdog_q - WD_W'(1);
                    if (state_q == ST_WAIT_HI && bus.fl_busy)  state_d = ST_WAIT_LO;
                    if (state_q == ST_WAIT_LO && !bus.fl_busy) state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (loaded_q) begin
                    checksum_d  = sum_q;
                    cks_valid_d = 1'b1;
                end
                if (last) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + REGION_W'(1);
                    state_d = ST_ARM;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (reload_i) begin
                    state_d     = ST_IDLE;
                    idx_d       = '0;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    cks_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (hit) sum_d = sum_q + {8'h00, bus.fl_q};
    end

    assign spi_sel_flash_o  = !((state_q == ST_DONE) || (state_q == ST_ERROR));
    assign hold_reset_o     = !done_q;
    assign done_o           = done_q;
    assign error_o          = error_q;
    assign err_region_o     = err_region_q;
    assign checksum_o       = checksum_q;
    assign checksum_valid_o = cks_valid_q;

endmodule

// File: tb/tb_flash_load_sequencer.sv
// Bench: behavioural flash reader backed by a byte array, a reference model
// derived from the region table, and a scoreboard monitor on the write port.
module tb_flash_load_sequencer;

    localparam int          A_BITS  = 14;
    localparam int          RW      = 1;
    localparam int unsigned TIMEOUT = 16;
    localparam logic [15:0] S0 = 16'h0200, S1 = 16'h1100;
    localparam logic [23:0] O0 = 24'h000000, O1 = 24'h000100;
    localparam logic [15:0] N0 = 16'd4, N1 = 16'd2;

    typedef struct packed {
        logic [A_BITS-1:0] addr;
        logic [7:0]        data;
        logic [RW-1:0]     rgn;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic slot_valid = 1'b0;
    logic reload_main = 1'b0;
    logic reload_mid = 1'b0;
    logic reload;
    logic [1:0] region_en = 2'b11;
    logic spi_sel, hold_reset, done, error, cv;
    logic [RW-1:0] err_region;
    logic [15:0] checksum;

    assign reload = reload_main | reload_mid;
    always #5 clk = ~clk;

    flash_load_if #(.A_BITS(A_BITS), .REGION_W(RW)) fif ();

    flash_load_sequencer #(
        .REGIONS       (2),
        .A_BITS        (A_BITS),
        .START_ADDRS   ({S1, S0}),
        .FLASH_OFFSETS ({O1, O0}),
        .AMOUNTS       ({N1, N0}),
        .TIMEOUT       (TIMEOUT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .slot_valid_i     (slot_valid),
        .region_en_i      (region_en),
        .reload_i         (reload),
        .bus              (fif),
        .spi_sel_flash_o  (spi_sel),
        .hold_reset_o     (hold_reset),
        .done_o           (done),
        .error_o          (error),
        .err_region_o     (err_region),
        .checksum_o       (checksum),
        .checksum_valid_o (cv)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] t_start(input int r);
        return (r == 0) ? S0 : S1;
    endfunction
    function automatic logic [23:0] t_off(input int r);
        return (r == 0) ? O0 : O1;
    endfunction
    function automatic logic [15:0] t_amt(input int r);
        return (r == 0) ? N0 : N1;
    endfunction

    logic [7:0] fmem [512];
    wr_t         exp_wr[$];
    int          exp_start[$];
    logic [15:0] exp_cks[$];

    // Reference model: every enabled, non-empty region copies its bytes in order.
    task automatic push_run(input logic [1:0] mask);
        for (int r = 0; r < 2; r++) begin
            logic [15:0] n = t_amt(r);
            logic [15:0] s = 16'h0000;
            if (mask[r] && n != 16'd0) begin
                exp_start.push_back(r);
                for (int k = 0; k < int'(n); k++) begin
                    wr_t w;
                    w.addr = A_BITS'(t_start(r) + 16'(k));
                    w.data = fmem[9'(t_off(r) + 24'(k))];
                    w.rgn  = RW'(r);
                    exp_wr.push_back(w);
                    s = s + {8'h00, w.data};
                end
                exp_cks.push_back(s);
            end
        end
    endtask

    task automatic fill_random();
        logic [15:0] s0 = 16'h0000;
        logic [15:0] s1 = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            fmem[i] = 8'($urandom);
            s0 = s0 + {8'h00, fmem[i]};
        end
        for (int i = 0; i < 2; i++) begin
            fmem[256 + i] = 8'($urandom);
            s1 = s1 + {8'h00, fmem[256 + i]};
        end
        if (s0 == s1) fmem[256] = fmem[256] + 8'd1;
    endtask

    // Behavioural flash reader.
    logic consec = 1'b0, dead = 1'b0, hang = 1'b0, mid_reload = 1'b0;
    logic hang_up = 1'b0, hang_go = 1'b0, hang_rel = 1'b0;

    task automatic serve();
        logic [15:0] a = fif.fl_start_addr;
        logic [15:0] n = fif.fl_amount;
        logic [23:0] o = fif.fl_offset;
        bit fall_same;
        int g;
        fall_same = $urandom_range(0, 1) != 0;
        fif.fl_busy = 1'b1;
        if (hang && a == S1) begin
            hang_up = 1'b1;
            while (!hang_go) @(posedge clk);
            repeat (10) @(posedge clk);
            #1;
            fif.fl_busy = 1'b0;
            hang_rel = 1'b1;
            return;
        end
        for (int k = 0; k < int'(n); k++) begin
            g = consec ? 1 : int'($urandom_range(1, 2));
            repeat (g) @(posedge clk);
            #1;
            reload_mid = 1'b0;
            fif.fl_a   = A_BITS'(a + 16'(k));
            fif.fl_q   = fmem[9'(o + 24'(k))];
            fif.fl_req = ~fif.fl_req;
            if (mid_reload && k == 1 && a == S0) begin
                reload_mid = 1'b1;
                mid_reload = 1'b0;
            end
            if (k == int'(n) - 1 && fall_same) fif.fl_busy = 1'b0;
        end
        if (fif.fl_busy || reload_mid) begin
            @(posedge clk);
            #1;
            fif.fl_busy = 1'b0;
            reload_mid  = 1'b0;
        end
    endtask

    initial begin : flash_model
        fif.fl_busy = 1'b0;
        fif.fl_req  = 1'b1;
        fif.fl_a    = '0;
        fif.fl_q    = '0;
        forever begin
            @(posedge clk);
            #1;
            if (fif.fl_start && !reset && !dead) serve();
        end
    end

    // Scoreboard monitor, sampling on the falling edge.
    logic        mon_on = 1'b0;
    logic        prev_req = 1'b0;
    bit          primed = 1'b0;
    logic        prev_cv = 1'b0;
    logic [15:0] prev_ck = 16'h0000;
    int          run_len = 0, max_run = 0, n_start = 0;
    wr_t         mw;
    int          mr;
    logic [15:0] mck;

    always @(negedge clk) begin
        if (mon_on) begin
            if (primed) check(fif.fl_ack == prev_req, "fl_ack_lag", 32'(fif.fl_ack), 32'(prev_req));
            if (fif.wr_en) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
                check(exp_wr.size() != 0, "wr_expected", 32'(fif.wr_addr), 32'd0);
                if (exp_wr.size() != 0) begin
                    mw = exp_wr.pop_front();
                    check(fif.wr_addr == mw.addr, "wr_addr", 32'(fif.wr_addr), 32'(mw.addr));
                    check(fif.wr_data == mw.data, "wr_data", 32'(fif.wr_data), 32'(mw.data));
                    check(fif.wr_region == mw.rgn, "wr_region", 32'(fif.wr_region), 32'(mw.rgn));
                end
            end else begin
                run_len = 0;
            end
            if (fif.fl_start) begin
                n_start++;
                check(exp_start.size() != 0, "start_expected", 32'(fif.fl_start_addr), 32'd0);
                if (exp_start.size() != 0) begin
                    mr = exp_start.pop_front();
                    check(fif.fl_start_addr == t_start(mr), "fl_start_addr", 32'(fif.fl_start_addr), 32'(t_start(mr)));
                    check(fif.fl_offset == t_off(mr), "fl_offset", 32'(fif.fl_offset), 32'(t_off(mr)));
                    check(fif.fl_amount == t_amt(mr), "fl_amount", 32'(fif.fl_amount), 32'(t_amt(mr)));
                end
            end
            if (cv && (!prev_cv || checksum != prev_ck)) begin
                check(exp_cks.size() != 0, "cksum_expected", 32'(checksum), 32'd0);
                if (exp_cks.size() != 0) begin
                    mck = exp_cks.pop_front();
                    check(checksum == mck, "checksum", 32'(checksum), 32'(mck));
                end
            end
        end
        prev_cv  = cv;
        prev_ck  = checksum;
        prev_req = fif.fl_req;
        primed   = 1'b1;
    end

    task automatic pulse_reload();
        @(posedge clk);
        #1 reload_main = 1'b1;
        @(posedge clk);
        #1 reload_main = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(done == 1'b1, "done_in_budget", 32'(n), 32'(limit));
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_finished(input string tag);
        check(exp_wr.size() == 0, {tag, "_writes_left"}, 32'(exp_wr.size()), 32'd0);
        check(exp_start.size() == 0, {tag, "_starts_left"}, 32'(exp_start.size()), 32'd0);
        check(exp_cks.size() == 0, {tag, "_cksums_left"}, 32'(exp_cks.size()), 32'd0);
        check(hold_reset == 1'b0, {tag, "_hold_reset"}, 32'(hold_reset), 32'd0);
        check(spi_sel == 1'b0, {tag, "_spi_sel"}, 32'(spi_sel), 32'd0);
        check(error == 1'b0, {tag, "_error"}, 32'(error), 32'd0);
        check(cv == 1'b1, {tag, "_cks_valid"}, 32'(cv), 32'd1);
    endtask

    initial begin : main
        int n;
        int starts_before;
        repeat (3) @(negedge clk);
        check(fif.fl_start == 1'b0, "rst_fl_start", 32'(fif.fl_start), 32'd0);
        check(fif.wr_en == 1'b0, "rst_wr_en", 32'(fif.wr_en), 32'd0);
        check(done == 1'b0, "rst_done", 32'(done), 32'd0);
        check(error == 1'b0, "rst_error", 32'(error), 32'd0);
        check(checksum == 16'h0000, "rst_checksum", 32'(checksum), 32'd0);
        check(cv == 1'b0, "rst_cks_valid", 32'(cv), 32'd0);
        check(err_region == '0, "rst_err_region", 32'(err_region), 32'd0);
        check(hold_reset == 1'b1, "rst_hold_reset", 32'(hold_reset), 32'd1);
        check(spi_sel == 1'b1, "rst_spi_sel", 32'(spi_sel), 32'd1);
        check(fif.fl_ack == 1'b1, "rst_fl_ack", 32'(fif.fl_ack), 32'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        mon_on = 1'b1;
        repeat (5) @(negedge clk);

        // Fixed bytes, back-to-back toggles in region 0.
        for (int i = 0; i < 4; i++) fmem[i] = 8'(i + 1);
        fmem[256] = 8'h10;
        fmem[257] = 8'h20;
        consec = 1'b1;
        max_run = 0;
        push_run(2'b11);
        @(posedge clk);
        #1 slot_valid = 1'b1;
        wait_done(300);
        check_finished("runA");
        check(checksum == 16'h0030, "runA_final_cks", 32'(checksum), 32'h30);
        check(max_run >= 3, "b2b_strobes", 32'(max_run), 32'd3);

        // Reload from DONE with a reload pulse during WAIT_LO that must be ignored.
        mid_reload = 1'b1;
        push_run(2'b11);
        pulse_reload();
        wait_done(300);
        check_finished("reload");
        check(checksum == 16'h0030, "reload_final_cks", 32'(checksum), 32'h30);
        check(mid_reload == 1'b0, "mid_reload_issued", 32'(mid_reload), 32'd0);
        consec = 1'b0;

        // Region 0 disabled.
        region_en = 2'b10;
        fill_random();
        push_run(2'b10);
        n_start = 0;
        pulse_reload();
        wait_done(300);
        check_finished("skip0");
        check(n_start == 1, "skip0_start_count", 32'(n_start), 32'd1);

        // Reset in WAIT_LO of region 1 while the reader stays busy.
        region_en = 2'b11;
        fill_random();
        hang = 1'b1;
        push_run(2'b01);
        exp_start.push_back(1);
        pulse_reload();
        n = 0;
        while (!hang_up && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(hang_up == 1'b1, "hang_reached", 32'(n), 32'd300);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        starts_before = n_start;
        hang_go = 1'b1;
        n = 0;
        while (!hang_rel && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(hang_rel == 1'b1, "hang_released", 32'(n), 32'd100);
        check(n_start == starts_before, "no_start_while_busy", 32'(n_start), 32'(starts_before));
        hang = 1'b0;
        push_run(2'b11);
        wait_done(300);
        check_finished("rst_mid");

        // Reader never goes busy: watchdog expires in region 0.
        dead = 1'b1;
        exp_start.push_back(0);
        pulse_reload();
        n = 0;
        while (!error && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(error == 1'b1, "wdog_error", 32'(error), 32'd1);
        repeat (3) @(negedge clk);
        check(err_region == '0, "wdog_err_region", 32'(err_region), 32'd0);
        check(hold_reset == 1'b1, "wdog_hold_reset", 32'(hold_reset), 32'd1);
        check(done == 1'b0, "wdog_done", 32'(done), 32'd0);
        check(spi_sel == 1'b0, "wdog_spi_sel", 32'(spi_sel), 32'd0);
        check(exp_start.size() == 0, "wdog_starts_left", 32'(exp_start.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
